// File: rtl/bram2be_pipe.sv
// Single-clock true dual-port byte-enable BRAM with configurable output latency and valid strobes.
// Optional post-reset memory clear is enabled by defining BRAM2BE_PIPE_CLEAR_EN.
module bram2be_pipe #(
   parameter int ADDR_WIDTH   = 10,
   parameter int CHUNKSIZE    = 8,
   parameter int WE_WIDTH     = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int MEMSIZE      = 1024,
   parameter int READ_LATENCY = 1,
   parameter int WRITE_MODE   = 0
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   output logic                  RDY,
   input  logic                  ENA,
   input  logic [WE_WIDTH-1:0]   WEA,
   input  logic [ADDR_WIDTH-1:0] ADDRA,
   input  logic [DATA_WIDTH-1:0] DIA,
   output logic [DATA_WIDTH-1:0] DOA,
   output logic                  DOA_VALID,
   input  logic                  ENB,
   input  logic [WE_WIDTH-1:0]   WEB,
   input  logic [ADDR_WIDTH-1:0] ADDRB,
   input  logic [DATA_WIDTH-1:0] DIB,
   output logic [DATA_WIDTH-1:0] DOB,
   output logic                  DOB_VALID
);
   localparam int L  = READ_LATENCY;
   localparam int IW = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

   if (DATA_WIDTH != CHUNKSIZE * WE_WIDTH) begin : g_bad_width
      $error("bram2be_pipe: DATA_WIDTH must equal CHUNKSIZE*WE_WIDTH");
   end
   if (64'(MEMSIZE) > (64'd1 << ADDR_WIDTH)) begin : g_bad_memsize
      $error("bram2be_pipe: MEMSIZE exceeds address space");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
      $error("bram2be_pipe: READ_LATENCY must be 1..3");
   end
   if (WRITE_MODE != 0 && WRITE_MODE != 1) begin : g_bad_mode
      $error("bram2be_pipe: WRITE_MODE must be 0 or 1");
   end

   logic [DATA_WIDTH-1:0] mem [MEMSIZE];

   logic                       rdy;
   logic                       clr_we;
   logic [IW-1:0]              clr_idx;
   logic [1:0]                 acc, inr;
   logic                       same;
   logic [1:0][WE_WIDTH-1:0]   we, wr;
   logic [1:0][ADDR_WIDTH-1:0] addr;
   logic [1:0][IW-1:0]         idx;
   logic [1:0][DATA_WIDTH-1:0] di, old, comb, resp;

`ifdef BRAM2BE_PIPE_CLEAR_EN
   localparam logic [1:0] S_RESET = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_READY = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [IW-1:0] clr_cnt_q, clr_cnt_d;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         S_RESET: begin
            state_d   = S_CLEAR;
            clr_cnt_d = '0;
         end
         S_CLEAR: begin
            if (clr_cnt_q == IW'(MEMSIZE - 1)) state_d = S_READY;
            else                               clr_cnt_d = clr_cnt_q + 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q   <= S_RESET;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   assign clr_we  = RST_N && (state_q == S_CLEAR);
   assign clr_idx = clr_cnt_q;
   assign rdy     = (state_q == S_READY);
`else
   logic rdy_q, rdy_d;

   always_comb rdy_d = 1'b1;

   always_ff @(posedge CLK) begin
      if (!RST_N) rdy_q <= 1'b0;
      else        rdy_q <= rdy_d;
   end

   assign clr_we  = 1'b0;
   assign clr_idx = '0;
   assign rdy     = rdy_q;
`endif

   assign RDY = rdy;

   // Port 0 is A, port 1 is B; on a shared lane A takes priority everywhere.
   always_comb begin
      we   = {WEB, WEA};
      addr = {ADDRB, ADDRA};
      di   = {DIB, DIA};
      acc  = {ENB, ENA} & {2{rdy & RST_N}};
      same = acc[0] & acc[1] & (addr[0] == addr[1]);
      for (int p = 0; p < 2; p++) begin
         inr[p] = ({1'b0, addr[p]} < (ADDR_WIDTH + 1)'(MEMSIZE));
         idx[p] = addr[p][IW-1:0];
         wr[p]  = (acc[p] && inr[p]) ? we[p] : '0;
         old[p] = inr[p] ? mem[idx[p]] : '0;
      end
      comb = old;
      for (int p = 0; p < 2; p++) begin
         for (int j = 0; j < WE_WIDTH; j++) begin
            if (wr[0][j] && (p == 0 || same))
               comb[p][j*CHUNKSIZE +: CHUNKSIZE] = di[0][j*CHUNKSIZE +: CHUNKSIZE];
            else if (wr[1][j] && (p == 1 || same))
               comb[p][j*CHUNKSIZE +: CHUNKSIZE] = di[1][j*CHUNKSIZE +: CHUNKSIZE];
         end
         resp[p] = !inr[p] ? '0 : ((WRITE_MODE == 0) ? comb[p] : old[p]);
      end
   end

   // B is written before A so the later non-blocking update lets A win a shared lane.
   always_ff @(posedge CLK) begin
      if (clr_we) mem[clr_idx] <= '0;
      for (int j = 0; j < WE_WIDTH; j++)
         if (wr[1][j]) mem[idx[1]][j*CHUNKSIZE +: CHUNKSIZE] <= DIB[j*CHUNKSIZE +: CHUNKSIZE];
      for (int j = 0; j < WE_WIDTH; j++)
         if (wr[0][j]) mem[idx[0]][j*CHUNKSIZE +: CHUNKSIZE] <= DIA[j*CHUNKSIZE +: CHUNKSIZE];
   end

   // Stage 0 captures the response at acceptance; stage L drives the outputs and holds between strobes.
   logic [1:0][L:0]                 vld_pipe_q, vld_pipe_d;
   logic [1:0][L:0][DATA_WIDTH-1:0] dat_pipe_q, dat_pipe_d;

   always_comb begin
      dat_pipe_d = dat_pipe_q;
      for (int p = 0; p < 2; p++) begin
         vld_pipe_d[p] = {vld_pipe_q[p][L-1:0], acc[p]};
         if (acc[p]) dat_pipe_d[p][0] = resp[p];
         for (int k = 1; k <= L; k++)
            if (vld_pipe_q[p][k-1]) dat_pipe_d[p][k] = dat_pipe_q[p][k-1];
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         vld_pipe_q <= '0;
         dat_pipe_q <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         dat_pipe_q <= dat_pipe_d;
      end
   end

   assign DOA       = dat_pipe_q[0][L];
   assign DOA_VALID = vld_pipe_q[0][L];
   assign DOB       = dat_pipe_q[1][L];
   assign DOB_VALID = vld_pipe_q[1][L];

endmodule

// File: tb/tb_bram2be_pipe.sv
// Scoreboard bench: two instances (write-first latency 2, read-first latency 3) share stimulus
// and are checked against a word-array memory model.
module tb_bram2be_pipe;
   localparam int AW = 5;
   localparam int MS = 16;
   localparam int L0 = 2;
   localparam int L1 = 3;
`ifdef BRAM2BE_PIPE_CLEAR_EN
   localparam int RDY_DLY = MS + 1;
`else
   localparam int RDY_DLY = 1;
`endif

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ena = 1'b0, enb = 1'b0;
   logic [3:0]    wea = '0, web = '0;
   logic [AW-1:0] addra = '0, addrb = '0;
   logic [31:0]   dia = '0, dib = '0;
   logic          rdy [2];
   logic [31:0]   doa [2];
   logic [31:0]   dob [2];
   logic          doa_v [2];
   logic          dob_v [2];

   exp_t          expq [4][$];
   logic [31:0]   mdl [MS];
   logic [31:0]   last [4] = '{default: 32'h0};
   int            cyc = 0;
   int            rel_cnt = 0;
   int            vectors = 0;
   int            miscompares = 0;

   bram2be_pipe #(.ADDR_WIDTH(AW), .MEMSIZE(MS), .READ_LATENCY(L0), .WRITE_MODE(0)) u_wf (
      .CLK(clk), .RST_N(rst_n), .RDY(rdy[0]),
      .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa[0]), .DOA_VALID(doa_v[0]),
      .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob[0]), .DOB_VALID(dob_v[0]));

   bram2be_pipe #(.ADDR_WIDTH(AW), .MEMSIZE(MS), .READ_LATENCY(L1), .WRITE_MODE(1)) u_rf (
      .CLK(clk), .RST_N(rst_n), .RDY(rdy[1]),
      .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa[1]), .DOA_VALID(doa_v[1]),
      .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob[1]), .DOB_VALID(dob_v[1]));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rel_cnt <= rst_n ? rel_cnt + 1 : 0;
   end

   function automatic logic [31:0] mrd(input logic [AW-1:0] a);
      return (int'(a) < MS) ? mdl[a] : 32'h0;
   endfunction

   function automatic void mwr(input logic [AW-1:0] a, input logic [3:0] w, input logic [31:0] d);
      if (int'(a) < MS)
         for (int j = 0; j < 4; j++)
            if (w[j]) mdl[a][j*8 +: 8] = d[j*8 +: 8];
   endfunction

   task automatic push(input int id, input logic [31:0] d, input int due);
      exp_t e;
      e.data = d;
      e.due  = due;
      expq[id].push_back(e);
   endtask

   // One request cycle: drive pins, update the model, then step to just after the edge.
   task automatic drive(input logic ea, input logic [3:0] wa, input logic [AW-1:0] aa, input logic [31:0] da,
                        input logic eb, input logic [3:0] wb, input logic [AW-1:0] ab, input logic [31:0] db,
                        input logic rn);
      logic [31:0] oa, ob;
      bit acc;
      ena = ea; wea = wa; addra = aa; dia = da;
      enb = eb; web = wb; addrb = ab; dib = db;
      rst_n = rn;
      acc = rn && (rel_cnt >= RDY_DLY);
      if (!rn)
         for (int i = 0; i < 4; i++)
            while (expq[i].size() > 0 && expq[i][expq[i].size()-1].due > cyc)
               void'(expq[i].pop_back());
`ifdef BRAM2BE_PIPE_CLEAR_EN
      if (rn && rel_cnt == 0)
         for (int i = 0; i < MS; i++) mdl[i] = 32'h0;
`endif
      if (acc) begin
         oa = mrd(aa);
         ob = mrd(ab);
         if (eb) mwr(ab, wb, db);
         if (ea) mwr(aa, wa, da);
         if (ea) begin
            push(0, mrd(aa), cyc + 1 + L0);
            push(2, oa, cyc + 1 + L1);
         end
         if (eb) begin
            push(1, mrd(ab), cyc + 1 + L0);
            push(3, ob, cyc + 1 + L1);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic rn);
      drive(1'b0, 4'h0, '0, 32'h0, 1'b0, 4'h0, '0, 32'h0, rn);
   endtask

   task automatic chk(input int id, input logic v, input logic [31:0] d);
      exp_t e;
      vectors++;
      if (v) begin
         if (expq[id].size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_valid port%0d cyc=%0d got=%h want=no response", id, cyc, d);
         end else begin
            e = expq[id].pop_front();
            if (d !== e.data || cyc != e.due) begin
               miscompares++;
               $display("FAIL response port%0d got=%h@%0d want=%h@%0d", id, d, cyc, e.data, e.due);
            end
            last[id] = e.data;
         end
      end else begin
         if (rel_cnt == 0) last[id] = 32'h0;
         if (expq[id].size() > 0 && expq[id][0].due <= cyc) begin
            miscompares++;
            $display("FAIL missing_valid port%0d cyc=%0d got=none want=%h@%0d",
                     id, cyc, expq[id][0].data, expq[id][0].due);
            void'(expq[id].pop_front());
         end else if (d !== last[id]) begin
            miscompares++;
            $display("FAIL hold port%0d cyc=%0d got=%h want=%h", id, cyc, d, last[id]);
         end
      end
   endtask

   always @(negedge clk) begin
      chk(0, doa_v[0], doa[0]);
      chk(1, dob_v[0], dob[0]);
      chk(2, doa_v[1], doa[1]);
      chk(3, dob_v[1], dob[1]);
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (rdy[k] !== (rel_cnt >= RDY_DLY)) begin
            miscompares++;
            $display("FAIL rdy dut%0d cyc=%0d got=%b want=%b", k, cyc, rdy[k], rel_cnt >= RDY_DLY);
         end
      end
   end

   initial begin
      logic [AW-1:0] ra, rb;
      logic [3:0]    rwa, rwb;
      repeat (3) idle(1'b0);
      // Requests held during the ready delay must not be accepted.
      repeat (RDY_DLY + 1) drive(1'b1, 4'h0, 5'd3, 32'h0, 1'b1, 4'hF, 5'd4, 32'h1, 1'b1);

      for (int a = 0; a < MS; a++) drive(1'b1, 4'hF, AW'(a), $urandom, 1'b0, 4'h0, '0, 32'h0, 1'b1);

      drive(1'b1, 4'hF, 5'd5, 32'h11223344, 1'b0, 4'h0, '0, 32'h0, 1'b1);
      drive(1'b0, 4'h0, '0, 32'h0, 1'b1, 4'h0, 5'd5, 32'h0, 1'b1);
      drive(1'b1, 4'b0101, 5'd5, 32'hAABBCCDD, 1'b0, 4'h0, '0, 32'h0, 1'b1);
      drive(1'b1, 4'h0, 5'd5, 32'h0, 1'b1, 4'h0, 5'd5, 32'h0, 1'b1);
      drive(1'b1, 4'hF, 5'd7, 32'h0, 1'b1, 4'hF, 5'd9, 32'h0, 1'b1);
      drive(1'b1, 4'b0011, 5'd7, 32'h0000AAAA, 1'b1, 4'b0110, 5'd7, 32'h00BBBB00, 1'b1);
      drive(1'b1, 4'h0, 5'd7, 32'h0, 1'b0, 4'h0, '0, 32'h0, 1'b1);
      drive(1'b1, 4'hF, 5'd9, 32'hDEADBEEF, 1'b1, 4'h0, 5'd9, 32'h0, 1'b1);
      drive(1'b1, 4'h0, 5'd9, 32'h0, 1'b1, 4'hF, 5'd9, 32'h12345678, 1'b1);
      drive(1'b1, 4'hF, 5'd20, 32'hFFFFFFFF, 1'b1, 4'h0, 5'd20, 32'h0, 1'b1);
      drive(1'b1, 4'h0, 5'd31, 32'h0, 1'b1, 4'hF, 5'd4, 32'hCAFEF00D, 1'b1);

      for (int i = 0; i < 16; i++)
         drive(1'b1, 4'h0, AW'(i), 32'h0, 1'b1, 4'h0, AW'(15 - i), 32'h0, (i != 8));
      repeat (RDY_DLY + 1) drive(1'b1, 4'h0, 5'd1, 32'h0, 1'b0, 4'h0, '0, 32'h0, 1'b1);
      for (int i = 0; i < MS; i++)
         drive(1'b1, 4'h0, AW'(i), 32'h0, 1'b1, 4'h0, AW'(MS - 1 - i), 32'h0, 1'b1);

      repeat (400) begin
         ra  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
         rb  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
         rwa = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
         rwb = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
         drive(($urandom_range(0, 3) != 0), rwa, ra, $urandom,
               ($urandom_range(0, 3) != 0), rwb, rb, $urandom,
               ($urandom_range(0, 79) != 0));
      end
      repeat (RDY_DLY + 8) idle(1'b1);

      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (expq[i].size() != 0) begin
            miscompares++;
            $display("FAIL drain port%0d got=%0d pending want=0", i, expq[i].size());
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
